// File: rtl/register_sequencer_pkg.sv
// rtl/register_sequencer_pkg.sv - shared encodings for the register sequencer
// Purpose: command, request-op and FSM state encodings shared by the sequencer,
//          its shift counter and the 4-bit command register.
// Ports:   none (package).
package register_sequencer_pkg;

    localparam int DEF_DATA_WIDTH  = 4;
    localparam int DEF_COUNT_WIDTH = 3;
    localparam int DEF_CMD_WIDTH   = 3;

    // Commands understood by the register (sampled on its negedge)
    localparam logic [2:0] CMD_HOLD  = 3'b000;
    localparam logic [2:0] CMD_RESET = 3'b001;
    localparam logic [2:0] CMD_LOAD  = 3'b010;
    localparam logic [2:0] CMD_SHL   = 3'b011;
    localparam logic [2:0] CMD_SHR   = 3'b100;

    // Request operations; 11x is illegal
    localparam logic [2:0] OP_CLEAR    = 3'b000;
    localparam logic [2:0] OP_LOAD     = 3'b001;
    localparam logic [2:0] OP_SHL      = 3'b010;
    localparam logic [2:0] OP_SHR      = 3'b011;
    localparam logic [2:0] OP_LOAD_SHL = 3'b100;
    localparam logic [2:0] OP_LOAD_SHR = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[2:1] == 2'b11;
    endfunction

    function automatic logic op_shifts_left(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_LOAD_SHL);
    endfunction

endpackage

// File: rtl/register_sequencer_shift_counter.sv
// rtl/register_sequencer_shift_counter.sv - loadable shift down-counter with clamp
// Purpose: holds the number of shift cycles still to issue. The loaded count is
//          clamped to DATA_WIDTH since further logical shifts cannot change the value.
// Ports:   clk, resetn (sync active-low), load/load_count (capture a new count),
//          dec (one shift issued), zero (no shifts pending), last (one shift pending).
module shift_counter #(
    parameter int DATA_WIDTH  = 4,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_count,
    input  logic                   dec,
    output logic                   zero,
    output logic                   last
);

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(DATA_WIDTH);

    logic [COUNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_count > MAX_COUNT) ? MAX_COUNT : load_count;
        end else if (dec && !zero) begin
            cnt <= cnt - COUNT_WIDTH'(1);
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == COUNT_WIDTH'(1));

endmodule

// File: rtl/register_sequencer.sv
// rtl/register_sequencer.sv - expands op requests into timed register commands
// Purpose: accepts one CLEAR/LOAD/SHx/LOAD_SHx request over valid/ready, drives the
//          command register one command per cycle and tracks a shadow copy of it.
// Ports:   clockSequencer, resetSequencer (sync active-low);
//          reqValid/reqReady/reqOp/reqData/reqCount request handshake;
//          comandRegister/inputRegister to the register;
//          shadowValue, busy, donePulse, errPulse status.
module register_sequencer
    import register_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int CMD_WIDTH   = DEF_CMD_WIDTH
) (
    input  logic                   clockSequencer,
    input  logic                   resetSequencer,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [2:0]             reqOp,
    input  logic [DATA_WIDTH-1:0]  reqData,
    input  logic [COUNT_WIDTH-1:0] reqCount,
    output logic [CMD_WIDTH-1:0]   comandRegister,
    output logic [DATA_WIDTH-1:0]  inputRegister,
    output logic [DATA_WIDTH-1:0]  shadowValue,
    output logic                   busy,
    output logic                   donePulse,
    output logic                   errPulse
);

    state_e               state;
    state_e               state_nxt;
    logic [2:0]           op_q;
    logic [2:0]           op_sel;
    logic [CMD_WIDTH-1:0] cmd_nxt;
    logic                 err_nxt;
    logic                 accept;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero;
    logic                 cnt_last;

    assign reqReady = !busy && resetSequencer;
    assign accept   = reqValid && reqReady;

    // On the accepting edge the op register is not yet loaded, so decode the live request
    assign op_sel = (state == ST_IDLE) ? reqOp : op_q;

    shift_counter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_shift_counter (
        .clk        (clockSequencer),
        .resetn     (resetSequencer),
        .load       (cnt_load),
        .load_count (reqCount),
        .dec        (cnt_dec),
        .zero       (cnt_zero),
        .last       (cnt_last)
    );

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    case (reqOp)
                        OP_CLEAR:                       state_nxt = ST_CLR;
                        OP_LOAD, OP_LOAD_SHL,
                        OP_LOAD_SHR:                    state_nxt = ST_LOAD;
                        OP_SHL, OP_SHR:                 state_nxt = (reqCount != '0) ? ST_SHIFT : ST_DONE;
                        default:                        state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_CLR:   state_nxt = ST_DONE;
            ST_LOAD: begin
                if ((op_q == OP_LOAD_SHL || op_q == OP_LOAD_SHR) && !cnt_zero) begin
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_SHIFT: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Command for the cycle being entered
    always_comb begin
        cmd_nxt = CMD_WIDTH'(CMD_HOLD);
        case (state_nxt)
            ST_CLR:   cmd_nxt = CMD_WIDTH'(CMD_RESET);
            ST_LOAD:  cmd_nxt = CMD_WIDTH'(CMD_LOAD);
            ST_SHIFT: cmd_nxt = op_shifts_left(op_sel) ? CMD_WIDTH'(CMD_SHL) : CMD_WIDTH'(CMD_SHR);
            default:  cmd_nxt = CMD_WIDTH'(CMD_HOLD);
        endcase
        err_nxt = (state_nxt == ST_DONE) && op_is_illegal(op_sel);
    end

    always_ff @(posedge clockSequencer) begin
        if (!resetSequencer) begin
            state          <= ST_IDLE;
            op_q           <= OP_CLEAR;
            comandRegister <= CMD_WIDTH'(CMD_RESET);
            inputRegister  <= '0;
            shadowValue    <= '0;
            busy           <= 1'b0;
            donePulse      <= 1'b0;
            errPulse       <= 1'b0;
        end else begin
            state          <= state_nxt;
            comandRegister <= cmd_nxt;
            busy           <= (state_nxt != ST_IDLE);
            donePulse      <= (state_nxt == ST_DONE);
            errPulse       <= err_nxt;
            if (accept) begin
                op_q <= reqOp;
            end
            if (accept && state_nxt == ST_LOAD) begin
                inputRegister <= reqData;
            end
            // The register applied the current command at the negedge inside this
            // cycle, so the shadow takes the same effect at the edge that ends it.
            case (comandRegister)
                CMD_WIDTH'(CMD_RESET): shadowValue <= '0;
                CMD_WIDTH'(CMD_LOAD):  shadowValue <= inputRegister;
                CMD_WIDTH'(CMD_SHL):   shadowValue <= {shadowValue[DATA_WIDTH-2:0], 1'b0};
                CMD_WIDTH'(CMD_SHR):   shadowValue <= {1'b0, shadowValue[DATA_WIDTH-1:1]};
                default:               shadowValue <= shadowValue;
            endcase
        end
    end

endmodule

// File: tb/tb_register_sequencer.sv
// tb/tb_register_sequencer.sv - self-checking bench for register_sequencer
module tb_register_sequencer;

    logic       clk;
    logic       rstn;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [3:0] req_data;
    logic [2:0] req_count;
    logic [2:0] cmd;
    logic [3:0] in_reg;
    logic [3:0] shadow;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_shadow;
    logic [2:0] exp_cmds[$];

    register_sequencer dut (
        .clockSequencer (clk),
        .resetSequencer (rstn),
        .reqValid       (req_valid),
        .reqReady       (req_ready),
        .reqOp          (req_op),
        .reqData        (req_data),
        .reqCount       (req_count),
        .comandRegister (cmd),
        .inputRegister  (in_reg),
        .shadowValue    (shadow),
        .busy           (busy),
        .donePulse      (done),
        .errPulse       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Commands the register should see for a request, one per cycle
    task automatic build_cmds(input logic [2:0] op, input logic [2:0] cnt);
        int k;
        exp_cmds.delete();
        k = (cnt > 3'd4) ? 4 : int'(cnt);
        case (op)
            3'd0: exp_cmds.push_back(3'b001);
            3'd1: exp_cmds.push_back(3'b010);
            3'd2: for (int i = 0; i < k; i++) exp_cmds.push_back(3'b011);
            3'd3: for (int i = 0; i < k; i++) exp_cmds.push_back(3'b100);
            3'd4: begin
                exp_cmds.push_back(3'b010);
                for (int i = 0; i < k; i++) exp_cmds.push_back(3'b011);
            end
            3'd5: begin
                exp_cmds.push_back(3'b010);
                for (int i = 0; i < k; i++) exp_cmds.push_back(3'b100);
            end
            default: ;
        endcase
    endtask

    function automatic logic [3:0] reg_apply(input logic [2:0] c, input logic [3:0] v, input logic [3:0] d);
        case (c)
            3'b001:  return 4'h0;
            3'b010:  return d;
            3'b011:  return 4'((v * 2) % 16);
            3'b100:  return v / 2;
            default: return v;
        endcase
    endfunction

    // Whole-op result straight from the op semantics
    function automatic logic [3:0] op_result(input logic [2:0] op, input logic [3:0] start,
                                             input logic [3:0] d, input logic [2:0] cnt);
        int base;
        int k;
        base = start;
        if (op == 3'd0) base = 0;
        if (op == 3'd1 || op == 3'd4 || op == 3'd5) base = d;
        k = (op == 3'd0 || op == 3'd1 || op >= 3'd6) ? 0 : int'(cnt);
        if (op == 3'd2 || op == 3'd4) return 4'((base << k) % 16);
        if (op == 3'd3 || op == 3'd5) return 4'(base >> k);
        return 4'(base);
    endfunction

    task automatic run_req(input logic [2:0] op, input logic [3:0] d, input logic [2:0] cnt,
                           output logic [3:0] fin, output logic fin_err);
        int w;
        logic illegal;
        illegal = (op[2:1] == 2'b11);
        build_cmds(op, cnt);
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_count = cnt;
        tick();
        req_valid = 1'b0;
        foreach (exp_cmds[i]) begin
            chk("cmd", cmd, exp_cmds[i]);
            if (exp_cmds[i] == 3'b010) chk("load_data", in_reg, d);
            chk("busy_during", busy, 1);
            chk("no_early_done", done, 0);
            chk("ready_low", req_ready, 0);
            exp_shadow = reg_apply(exp_cmds[i], exp_shadow, d);
            tick();
            chk("shadow_step", shadow, exp_shadow);
        end
        chk("done_cmd_hold", cmd, 0);
        chk("done_pulse", done, 1);
        chk("err_pulse", err, illegal);
        chk("busy_in_done", busy, 1);
        fin_err = err;
        tick();
        chk("done_single", done, 0);
        chk("err_single", err, 0);
        chk("busy_after", busy, 0);
        chk("ready_after", req_ready, 1);
        fin = shadow;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic [2:0] count;
        logic [3:0] exp_shadow;
        logic       exp_err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [3:0] fin;
        logic       fin_err;
        logic [3:0] start;
        logic [2:0] rop;
        logic [3:0] rdata;
        logic [2:0] rcnt;

        tbl[0]  = '{3'd4, 4'b0011, 3'd2, 4'b1100, 1'b0};
        tbl[1]  = '{3'd1, 4'b1111, 3'd0, 4'b1111, 1'b0};
        tbl[2]  = '{3'd3, 4'b0000, 3'd7, 4'b0000, 1'b0};
        tbl[3]  = '{3'd1, 4'b0101, 3'd0, 4'b0101, 1'b0};
        tbl[4]  = '{3'd2, 4'b1111, 3'd0, 4'b0101, 1'b0};
        tbl[5]  = '{3'd6, 4'b1111, 3'd3, 4'b0101, 1'b1};
        tbl[6]  = '{3'd7, 4'b0000, 3'd1, 4'b0101, 1'b1};
        tbl[7]  = '{3'd2, 4'b0000, 3'd1, 4'b1010, 1'b0};
        tbl[8]  = '{3'd5, 4'b1001, 3'd5, 4'b0000, 1'b0};
        tbl[9]  = '{3'd5, 4'b1001, 3'd1, 4'b0100, 1'b0};
        tbl[10] = '{3'd0, 4'b1111, 3'd2, 4'b0000, 1'b0};
        tbl[11] = '{3'd4, 4'b0001, 3'd3, 4'b1000, 1'b0};
        tbl[12] = '{3'd4, 4'b0110, 3'd0, 4'b0110, 1'b0};
        tbl[13] = '{3'd3, 4'b0000, 3'd4, 4'b0000, 1'b0};

        rstn      = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_data  = 4'd0;
        req_count = 3'd0;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_cmd", cmd, 3'b001);
            chk("rst_shadow", shadow, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
        end
        rstn = 1'b1;
        tick();
        chk("post_rst_cmd", cmd, 3'b000);
        chk("post_rst_ready", req_ready, 1);
        exp_shadow = 4'h0;

        // Table vectors
        for (int i = 0; i < 14; i++) begin
            run_req(tbl[i].op, tbl[i].data, tbl[i].count, fin, fin_err);
            chk($sformatf("tbl%0d_shadow", i), fin, tbl[i].exp_shadow);
            chk($sformatf("tbl%0d_err", i), fin_err, tbl[i].exp_err);
        end

        // Back-to-back: valid held, second request waits for DONE->IDLE
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_data  = 4'h0;
        req_count = 3'd0;
        tick();
        req_op   = 3'd1;
        req_data = 4'b1010;
        chk("b2b_c1_cmd", cmd, 3'b001);
        chk("b2b_c1_ready", req_ready, 0);
        tick();
        chk("b2b_c2_done", done, 1);
        chk("b2b_c2_cmd", cmd, 3'b000);
        tick();
        chk("b2b_c3_ready", req_ready, 1);
        chk("b2b_c3_cmd", cmd, 3'b000);
        chk("b2b_c3_shadow", shadow, 0);
        tick();
        req_valid = 1'b0;
        chk("b2b_c4_cmd", cmd, 3'b010);
        chk("b2b_c4_data", in_reg, 4'b1010);
        tick();
        chk("b2b_c5_done", done, 1);
        chk("b2b_c5_shadow", shadow, 4'b1010);
        tick();
        chk("b2b_c6_ready", req_ready, 1);
        exp_shadow = 4'b1010;

        // Reset during SHIFT of LOAD_SHR 1000 count 3
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_data  = 4'b1000;
        req_count = 3'd3;
        tick();
        req_valid = 1'b0;
        chk("abort_c1_cmd", cmd, 3'b010);
        tick();
        chk("abort_c2_cmd", cmd, 3'b100);
        chk("abort_c2_shadow", shadow, 4'b1000);
        rstn = 1'b0;
        tick();
        chk("abort_cmd", cmd, 3'b001);
        chk("abort_shadow", shadow, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_idle_cmd", cmd, 3'b000);
            chk("abort_no_done", done, 0);
            chk("abort_idle_ready", req_ready, 1);
            chk("abort_idle_shadow", shadow, 0);
        end
        exp_shadow = 4'h0;

        // Randomized requests against the model
        for (int i = 0; i < 60; i++) begin
            rop   = 3'($urandom_range(0, 7));
            rdata = 4'($urandom_range(0, 15));
            rcnt  = 3'($urandom_range(0, 7));
            start = exp_shadow;
            for (int j = $urandom_range(0, 2); j > 0; j--) tick();
            run_req(rop, rdata, rcnt, fin, fin_err);
            chk("rand_final", fin, op_result(rop, start, rdata, rcnt));
            chk("rand_err", fin_err, (rop[2:1] == 2'b11));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
